toy_mem_responder: RTL
======================

Name: toy_mem_responder

Overview:
- Memory-side responder for the RISC_TOY instruction and data buses. It is the other end of IREQ/IADDR/INSTR and DREQ/DRW/DADDR/DWDATA/DRDATA.
- A single word-addressed storage array sits behind two ports:
  - a read-only instruction port;
  - a read/write data port.
- Both ports share a programmable read latency pipeline. Used as the memory model in the RISC_TOY system and in the core's testbench.

Parameters:
- DEPTH, 4096: number of 32-bit words; a power of two, minimum 16.
- RD_LAT, 1: read latency in cycles, request edge to data valid; legal range 1..4.
- OOR_DATA, 32'h0000_0000: value returned for out-of-range reads.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- IREQ  in  1  instruction fetch request.
- IADDR  in  30  instruction word address.
- INSTR  out  32  fetched instruction.
- IVALID  out  1  INSTR holds data for the request issued RD_LAT cycles earlier.
- DREQ  in  1  data request.
- DRW  in  1  direction: 1 = read, 0 = write.
- DADDR  in  30  data word address.
- DWDATA  in  32  write data.
- DRDATA  out  32  read data.
- DVALID  out  1  DRDATA holds data for the read issued RD_LAT cycles earlier.
- OOR_ERR  out  1  one-cycle pulse on any out-of-range request, either port.

Behaviour:
- Reset:
  - INSTR, DRDATA, IVALID, DVALID and OOR_ERR go to 0 immediately (asynchronous).
  - All latency-pipeline valid bits are cleared, so in-flight reads are discarded and never produce a valid.
  - Array contents are not cleared by reset.
- Address decode:
  - In range when addr < DEPTH. Index = addr[log2(DEPTH)-1:0].
  - Out of range: read returns OOR_DATA with valid still asserted; write is dropped. OOR_ERR pulses high the cycle after the offending request edge.
- Requests are sampled on every rising edge. There is no back-pressure: one request per port per cycle is always accepted.
- Write (DREQ=1, DRW=0): the array updates at the sampling edge. No response and no DVALID.
- Read latency:
  - Each read stage-0 captures {valid, data} at the sampling edge.
  - RD_LAT-1 further register stages follow. Outputs come from the last stage.
  - RD_LAT=1: data is visible the cycle after the request edge.
- Output hold: when the last stage holds no valid entry, INSTR/DRDATA keep their previous value and IVALID/DVALID are 0.
- Back-to-back reads on every cycle give one valid per cycle, in order, with no bubbles.
- Same-cycle data write and instruction read, same index: write-first. INSTR returns DWDATA.
- Same-cycle data write followed by a data read of the same index on the next cycle: returns the new data.
- DREQ=0 or IREQ=0: no array access; the pipeline stage-0 valid for that port is 0.
- Address bits above the index are checked only for the range test. They are never used for aliasing.
- RD_LAT outside 1..4: elaboration error.

Optional Feature:
- Macro: TOY_MEM_STATS_EN.
- Defined adds three outputs:
  - IRD_CNT [31:0]: accepted instruction reads.
  - DRD_CNT [31:0]: accepted data reads.
  - DWR_CNT [31:0]: accepted data writes.
- Counter rules:
  - Counters increment at the sampling edge.
  - Out-of-range requests are counted.
  - Counters wrap at 2^32.
  - Counters clear on RST.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Package toy_mem_pkg holds:
  - WORD_W=32 and ADDR_W=30;
  - the DRW encodings (DRW_READ=1, DRW_WRITE=0);
  - the RD_LAT limits (1..4).
- One sub-module, toy_mem_rd_pipe: a parameterized {valid, 32-bit data} delay line of depth RD_LAT with asynchronous clear. It is instantiated once per port.
- The storage array and decode stay in the top.

Test Plan:
- Reset/latency (RD_LAT=2):
  - Assert RST mid-read with 2 reads in flight → IVALID/DVALID stay 0 for 3 cycles after release.
  - Then write 0x1234_5678 to addr 5 and read addr 5 → DRDATA=0x1234_5678 with DVALID high exactly 2 cycles after the read edge.
- Streaming (RD_LAT=1):
  - Preload addr 0..7 with value = addr*3; IREQ every cycle for addr 0..7 → INSTR 0,3,…,21 on 8 consecutive cycles, IVALID continuously high.
- Write-first collision:
  - Same edge: DREQ write 0xCAFE_F00D to addr 9 and IREQ read addr 9 → INSTR=0xCAFE_F00D.
  - Read addr 9 on the next edge → DRDATA=0xCAFE_F00D.
- Out of range (DEPTH=16):
  - Write 0xFFFF_FFFF to addr 16, then read addr 16 → DRDATA=OOR_DATA=0 with DVALID=1; OOR_ERR pulses twice.
  - Addr 0 is unchanged.
- Stats (TOY_MEM_STATS_EN):
  - 5 instruction reads, 3 data reads, 2 data writes → IRD_CNT=5, DRD_CNT=3, DWR_CNT=2; all 0 after RST.
- Idle hold:
  - After a read of 0xA5A5_A5A5, drop DREQ for 4 cycles → DRDATA stays 0xA5A5_A5A5, DVALID=0.

Source files
------------

// File: rtl/toy_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : toy_mem_pkg
// Brief  : Shared widths, DRW encodings, latency limits and the read-beat type
//          for the RISC_TOY memory responder.
// Rev    : 1.0  initial release
// ============================================================================
package toy_mem_pkg;

    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 30;

    localparam logic DRW_READ  = 1'b1;
    localparam logic DRW_WRITE = 1'b0;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic              vld;
        logic [WORD_W-1:0] data;
    } rd_beat_t;

endpackage : toy_mem_pkg
`default_nettype wire

// File: rtl/toy_mem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module : toy_mem_rd_pipe
// Brief  : {valid, data} delay line of depth LAT with asynchronous clear; the
//          data field only advances with a valid beat so the tail holds.
// Rev    : 1.0  initial release
// ============================================================================
module toy_mem_rd_pipe
    import toy_mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rd_beat_t i_beat,
    output rd_beat_t o_beat
);

    rd_beat_t r_stg [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                r_stg[s] <= '0;
            end
        end else begin
            r_stg[0].vld <= i_beat.vld;
            if (i_beat.vld) begin
                r_stg[0].data <= i_beat.data;
            end
            for (int s = 1; s < LAT; s++) begin
                r_stg[s].vld <= r_stg[s-1].vld;
                if (r_stg[s-1].vld) begin
                    r_stg[s].data <= r_stg[s-1].data;
                end
            end
        end
    end

    assign o_beat = r_stg[LAT-1];

endmodule : toy_mem_rd_pipe
`default_nettype wire

// File: rtl/toy_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : toy_mem_responder
// Brief  : Word-addressed memory behind a read-only instruction port and a
//          read/write data port, with a shared programmable read latency.
//          Define TOY_MEM_STATS_EN to add IRD_CNT/DRD_CNT/DWR_CNT counters.
// Rev    : 1.0  initial release
// ============================================================================
module toy_mem_responder
    import toy_mem_pkg::*;
#(
    parameter int                DEPTH    = 4096,
    parameter int                RD_LAT   = 1,
    parameter logic [WORD_W-1:0] OOR_DATA = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IREQ,
    input  logic [ADDR_W-1:0] IADDR,
    output logic [WORD_W-1:0] INSTR,
    output logic              IVALID,
    input  logic              DREQ,
    input  logic              DRW,
    input  logic [ADDR_W-1:0] DADDR,
    input  logic [WORD_W-1:0] DWDATA,
    output logic [WORD_W-1:0] DRDATA,
    output logic              DVALID,
    output logic              OOR_ERR
`ifdef TOY_MEM_STATS_EN
    ,
    output logic [31:0]       IRD_CNT,
    output logic [31:0]       DRD_CNT,
    output logic [31:0]       DWR_CNT
`endif
);

    localparam int          c_IDX_W = $clog2(DEPTH);
    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
            $error("toy_mem_responder: RD_LAT must be within 1..4");
        end
        if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0 || c_IDX_W > ADDR_W) begin : g_bad_depth
            $error("toy_mem_responder: DEPTH must be a power of two, at least 16");
        end
    endgenerate

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic              r_oor;

    logic [c_IDX_W-1:0] w_i_idx;
    logic [c_IDX_W-1:0] w_d_idx;
    logic               w_i_inr;
    logic               w_d_inr;
    logic               w_wr_en;
    rd_beat_t           w_i_beat;
    rd_beat_t           w_d_beat;
    rd_beat_t           w_i_out;
    rd_beat_t           w_d_out;

    assign w_i_idx = IADDR[c_IDX_W-1:0];
    assign w_d_idx = DADDR[c_IDX_W-1:0];
    assign w_i_inr = (32'(IADDR) < c_DEPTH);
    assign w_d_inr = (32'(DADDR) < c_DEPTH);
    assign w_wr_en = DREQ && (DRW == DRW_WRITE) && w_d_inr;

    // Instruction reads see a same-edge data write to the same word (write-first).
    always_comb begin
        w_i_beat.vld  = IREQ;
        w_i_beat.data = OOR_DATA;
        if (w_i_inr) begin
            if (w_wr_en && (w_d_idx == w_i_idx)) begin
                w_i_beat.data = DWDATA;
            end else begin
                w_i_beat.data = r_mem[w_i_idx];
            end
        end
    end

    always_comb begin
        w_d_beat.vld  = DREQ && (DRW == DRW_READ);
        w_d_beat.data = w_d_inr ? r_mem[w_d_idx] : OOR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_d_idx] <= DWDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_oor <= 1'b0;
        end else begin
            r_oor <= (IREQ && !w_i_inr) || (DREQ && !w_d_inr);
        end
    end

    toy_mem_rd_pipe #(
        .LAT (RD_LAT)
    ) u_ipipe (
        .clk    (CLK),
        .rst    (RST),
        .i_beat (w_i_beat),
        .o_beat (w_i_out)
    );

    toy_mem_rd_pipe #(
        .LAT (RD_LAT)
    ) u_dpipe (
        .clk    (CLK),
        .rst    (RST),
        .i_beat (w_d_beat),
        .o_beat (w_d_out)
    );

    assign INSTR   = w_i_out.data;
    assign IVALID  = w_i_out.vld;
    assign DRDATA  = w_d_out.data;
    assign DVALID  = w_d_out.vld;
    assign OOR_ERR = r_oor;

`ifdef TOY_MEM_STATS_EN
    logic [31:0] r_ird_cnt;
    logic [31:0] r_drd_cnt;
    logic [31:0] r_dwr_cnt;

    // Out-of-range requests are still counted as accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ird_cnt <= '0;
            r_drd_cnt <= '0;
            r_dwr_cnt <= '0;
        end else begin
            if (IREQ) begin
                r_ird_cnt <= r_ird_cnt + 32'd1;
            end
            if (DREQ && (DRW == DRW_READ)) begin
                r_drd_cnt <= r_drd_cnt + 32'd1;
            end
            if (DREQ && (DRW == DRW_WRITE)) begin
                r_dwr_cnt <= r_dwr_cnt + 32'd1;
            end
        end
    end

    assign IRD_CNT = r_ird_cnt;
    assign DRD_CNT = r_drd_cnt;
    assign DWR_CNT = r_dwr_cnt;
`endif

endmodule : toy_mem_responder
`default_nettype wire
